correlation_vacc: RTL and testbench

CORRELATION_VACC -- requirements
Module: correlation_vacc

---
 rtl/correlation_vacc_pkg.sv | 14 +
 rtl/correlation_vacc_bram_sdp.sv | 22 ++
 rtl/correlation_vacc.sv | 181 ++++++++++++++++++
 tb/tb_correlation_vacc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/correlation_vacc_pkg.sv
// rtl/correlation_vacc_pkg.sv - shared FSM encoding and address-width helper for correlation_vacc
package correlation_vacc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACC   = 2'd2
  } vacc_state_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/correlation_vacc_bram_sdp.sv
// rtl/correlation_vacc_bram_sdp.sv - simple dual-port RAM, one write port, one read port, read latency 1
module bram_sdp #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/correlation_vacc.sv
// rtl/correlation_vacc.sv - per-channel vector accumulator for power and cross-correlation products
module correlation_vacc
  import correlation_vacc_pkg::*;
#(
  parameter int DIN_WIDTH  = 37,
  parameter int DOUT_WIDTH = 64,
  parameter int VECTOR_LEN = 64,
  localparam int AW        = addr_width(VECTOR_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIN_WIDTH-1:0]         din1_pow,
  input  logic [DIN_WIDTH-1:0]         din2_pow,
  input  logic signed [DIN_WIDTH-1:0]  corr_re,
  input  logic signed [DIN_WIDTH-1:0]  corr_im,
  input  logic                         din_valid,
  input  logic                         new_acc,
  output logic [DOUT_WIDTH-1:0]        r11_acc,
  output logic [DOUT_WIDTH-1:0]        r22_acc,
  output logic signed [DOUT_WIDTH-1:0] r12_re_acc,
  output logic signed [DOUT_WIDTH-1:0] r12_im_acc,
  output logic [AW-1:0]                dout_addr,
  output logic                         dout_valid
);

  localparam int DW  = DOUT_WIDTH;
  localparam int MW  = 4 * DOUT_WIDTH;
  localparam int PAD = DOUT_WIDTH - DIN_WIDTH;

  vacc_state_t   state;
  logic [AW-1:0] ch_cnt;
  logic          pending;
  logic          frame_ovr;
  logic          frame_emit;

  logic          boundary;
  logic          req;
  logic          s0_wr;
  logic          s0_ovr;
  logic          s0_emit;
  logic [MW-1:0] din_ext;

  logic          s1_valid;
  logic          s1_emit;
  logic          s1_ovr;
  logic [AW-1:0] s1_addr;
  logic [MW-1:0] s1_din;
  logic [MW-1:0] rd_data;
  logic [MW-1:0] upd_data;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_data;

  assign boundary = din_valid && (ch_cnt == '0);
  assign req      = pending | new_acc;

  // Memory word lanes, LSB first: r11, r22, r12_re, r12_im.
  assign din_ext = {{{PAD{corr_im[DIN_WIDTH-1]}}, corr_im},
                    {{PAD{corr_re[DIN_WIDTH-1]}}, corr_re},
                    {{PAD{1'b0}}, din2_pow},
                    {{PAD{1'b0}}, din1_pow}};

  // Boundary samples decide the frame's mode themselves; later samples follow the latched mode.
  always_comb begin
    s0_wr   = 1'b0;
    s0_ovr  = 1'b0;
    s0_emit = 1'b0;
    case (state)
      ST_ARMED: begin
        if (boundary) begin
          s0_wr  = 1'b1;
          s0_ovr = 1'b1;
        end
      end
      ST_ACC: begin
        if (din_valid) begin
          s0_wr = 1'b1;
          if (boundary) begin
            s0_ovr  = req;
            s0_emit = req;
          end else begin
            s0_ovr  = frame_ovr;
            s0_emit = frame_emit;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ch_cnt     <= '0;
      pending    <= 1'b0;
      frame_ovr  <= 1'b0;
      frame_emit <= 1'b0;
    end else begin
      if (din_valid) ch_cnt <= ch_cnt + AW'(1);
      case (state)
        ST_IDLE: begin
          if (new_acc) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (boundary) begin
            state      <= ST_ACC;
            frame_ovr  <= 1'b1;
            frame_emit <= 1'b0;
          end
        end
        ST_ACC: begin
          if (boundary) begin
            frame_ovr  <= req;
            frame_emit <= req;
            pending    <= 1'b0;
          end else if (new_acc) begin
            pending <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bram_sdp #(
    .WIDTH (MW),
    .DEPTH (VECTOR_LEN),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ch_cnt),
    .rd_data (rd_data)
  );

  always_comb begin
    upd_data = '0;
    for (int i = 0; i < 4; i++) begin
      upd_data[i*DW +: DW] = s1_ovr ? s1_din[i*DW +: DW]
                                    : rd_data[i*DW +: DW] + s1_din[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    s1_ovr  <= s0_ovr;
    s1_addr <= ch_cnt;
    s1_din  <= din_ext;
    wr_addr <= s1_addr;
    wr_data <= upd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_emit    <= 1'b0;
      wr_en      <= 1'b0;
      dout_valid <= 1'b0;
      dout_addr  <= '0;
      r11_acc    <= '0;
      r22_acc    <= '0;
      r12_re_acc <= '0;
      r12_im_acc <= '0;
    end else begin
      s1_valid   <= s0_wr;
      s1_emit    <= s0_emit;
      wr_en      <= s1_valid;
      dout_valid <= s1_valid && s1_emit;
      if (s1_valid && s1_emit) begin
        dout_addr  <= s1_addr;
        r11_acc    <= rd_data[0*DW +: DW];
        r22_acc    <= rd_data[1*DW +: DW];
        r12_re_acc <= $signed(rd_data[2*DW +: DW]);
        r12_im_acc <= $signed(rd_data[3*DW +: DW]);
      end
    end
  end

endmodule

// File: tb/tb_correlation_vacc.sv
// tb/tb_correlation_vacc.sv - randomized and directed self-checking bench for correlation_vacc
module tb_correlation_vacc;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [63:0] r11, r22, re, im;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [63:0] r11, r22, re, im;
    logic [39:0] re40;
  } cap_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [36:0] din1_pow = '0, din2_pow = '0, corr_re = '0, corr_im = '0;
  logic din_valid = 1'b0, new_acc = 1'b0;

  logic [63:0]        a_r11, a_r22;
  logic signed [63:0] a_re, a_im;
  logic [2:0]         a_addr;
  logic               a_valid;
  logic [39:0]        b_r11, b_r22;
  logic signed [39:0] b_re, b_im;
  logic [2:0]         b_addr;
  logic               b_valid;

  correlation_vacc #(.DIN_WIDTH(37), .DOUT_WIDTH(64), .VECTOR_LEN(8)) dut (
    .clk(clk), .rst(rst), .din1_pow(din1_pow), .din2_pow(din2_pow),
    .corr_re(corr_re), .corr_im(corr_im), .din_valid(din_valid), .new_acc(new_acc),
    .r11_acc(a_r11), .r22_acc(a_r22), .r12_re_acc(a_re), .r12_im_acc(a_im),
    .dout_addr(a_addr), .dout_valid(a_valid));

  correlation_vacc #(.DIN_WIDTH(37), .DOUT_WIDTH(40), .VECTOR_LEN(8)) dut40 (
    .clk(clk), .rst(rst), .din1_pow(din1_pow), .din2_pow(din2_pow),
    .corr_re(corr_re), .corr_im(corr_im), .din_valid(din_valid), .new_acc(new_acc),
    .r11_acc(b_r11), .r22_acc(b_r22), .r12_re_acc(b_re), .r12_im_acc(b_im),
    .dout_addr(b_addr), .dout_valid(b_valid));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  exp_t exp_q[$];
  cap_t cap_q[$];

  // Reference: per-channel integrations kept as plain 64-bit sums.
  int          m_state;  // 0 idle, 1 armed, 2 integrating
  bit          m_pend, m_fresh, m_dump;
  int          m_cnt;
  int          m_emits;
  logic [63:0] m11[8], m22[8], mre[8], mim[8];
  int          frame_start_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk = n_chk + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic logic [36:0] rnd37();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[36:0];
  endfunction

  task automatic model_sample(input bit v, input bit na, input logic [36:0] p1, p2, cr, ci);
    longint sre, sim;
    exp_t e;
    sre = $signed(cr);
    sim = $signed(ci);
    if (m_state == 0) begin
      if (na) m_state = 1;
    end else if (m_state == 1) begin
      if (v && m_cnt == 0) begin
        m_state = 2; m_fresh = 1; m_dump = 0;
      end
    end else begin
      if (v && m_cnt == 0) begin
        m_fresh = m_pend | na; m_dump = m_pend | na; m_pend = 0;
      end else if (na) begin
        m_pend = 1;
      end
    end
    if (v && m_state == 2) begin
      if (m_dump) begin
        e.cyc = cyc + 2; e.addr = 3'(m_cnt);
        e.r11 = m11[m_cnt]; e.r22 = m22[m_cnt]; e.re = mre[m_cnt]; e.im = mim[m_cnt];
        exp_q.push_back(e);
        m_emits++;
      end
      if (m_fresh) begin
        m11[m_cnt] = {27'd0, p1}; m22[m_cnt] = {27'd0, p2}; mre[m_cnt] = sre; mim[m_cnt] = sim;
      end else begin
        m11[m_cnt] += {27'd0, p1}; m22[m_cnt] += {27'd0, p2};
        mre[m_cnt] += sre; mim[m_cnt] += sim;
      end
    end
    if (v) m_cnt = (m_cnt + 1) % 8;
  endtask

  task automatic step(input bit v, input bit na, input logic [36:0] p1, p2, cr, ci);
    @(posedge clk); #1;
    din_valid = v; new_acc = na;
    din1_pow = p1; din2_pow = p2; corr_re = cr; corr_im = ci;
    model_sample(v, na, p1, p2, cr, ci);
  endtask

  task automatic idle(input int n, input bit na = 0);
    repeat (n) step(0, na, rnd37(), rnd37(), rnd37(), rnd37());
  endtask

  task automatic frame_const(input logic [36:0] p1, p2, cr, ci);
    for (int ch = 0; ch < 8; ch++) step(1, 0, p1, p2, cr, ci);
  endtask

  task automatic frame_rand(input int gap_pct, input logic [7:0] na_mask);
    for (int ch = 0; ch < 8; ch++) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
      step(1, na_mask[ch], rnd37(), rnd37(), rnd37(), rnd37());
      if (ch == 0) frame_start_cyc = cyc;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 0; din_valid = 0; new_acc = 0;
    m_state = 0; m_cnt = 0; m_pend = 0; m_fresh = 0; m_dump = 0;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    repeat (n) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_valid40", {63'd0, b_valid}, 64'd0);
    chk("rst_addr", {61'd0, a_addr}, 64'd0);
    chk("rst_r11", a_r11, 64'd0);
    chk("rst_re", a_re, 64'd0);
    chk("rst_im40", {24'd0, b_im}, 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cap_t c;
    if (b_valid !== a_valid) chk("valid_w40", {63'd0, b_valid}, {63'd0, a_valid});
    if (a_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
        chk("addr", {61'd0, a_addr}, {61'd0, e.addr});
        chk("r11", a_r11, e.r11);
        chk("r22", a_r22, e.r22);
        chk("r12_re", a_re, e.re);
        chk("r12_im", a_im, e.im);
        chk("r11_w40", {24'd0, b_r11}, {24'd0, e.r11[39:0]});
        chk("r22_w40", {24'd0, b_r22}, {24'd0, e.r22[39:0]});
        chk("re_w40", {24'd0, b_re}, {24'd0, e.re[39:0]});
        chk("im_w40", {24'd0, b_im}, {24'd0, e.im[39:0]});
      end
      c.cyc = cyc; c.addr = a_addr; c.r11 = a_r11; c.r22 = a_r22;
      c.re = a_re; c.im = a_im; c.re40 = b_re;
      cap_q.push_back(c);
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("missing_valid", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    m_state = 0; m_cnt = 0; m_pend = 0; m_fresh = 0; m_dump = 0; m_emits = 0;
    for (int i = 0; i < 8; i++) begin m11[i] = 0; m22[i] = 0; mre[i] = 0; mim[i] = 0; end

    do_reset(3);

    // Three frames without any dump request: nothing may come out.
    cap_q.delete();
    repeat (3) frame_rand(0, 8'h00);
    idle(4);
    chk("no_req_count", 64'(cap_q.size()), 64'd0);
    chk("no_req_r11", a_r11, 64'd0);
    chk("no_req_re", a_re, 64'd0);

    // Four constant frames, then a dump.
    idle(1, 1);
    repeat (4) frame_const(37'd5, 37'd3, 37'h1F_FFFF_FFFE, 37'd7);
    idle(1, 1);
    cap_q.delete();
    frame_const(37'd1, 37'd1, 37'd1, 37'd1);
    idle(4);
    chk("const_count", 64'(cap_q.size()), 64'd8);
    for (int i = 0; i < cap_q.size(); i++) begin
      chk("const_addr", {61'd0, cap_q[i].addr}, 64'(i));
      chk("const_r11", cap_q[i].r11, 64'd20);
      chk("const_r22", cap_q[i].r22, 64'd12);
      chk("const_re", cap_q[i].re, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("const_im", cap_q[i].im, 64'd28);
    end

    // Request at channel 5 must wait for the next channel-0 sample.
    cap_q.delete();
    frame_rand(0, 8'b0010_0000);
    idle(2);
    chk("mid_req_early", 64'(cap_q.size()), 64'd0);
    frame_rand(0, 8'h00);
    idle(4);
    chk("mid_req_count", 64'(cap_q.size()), 64'd8);
    if (cap_q.size() > 0) begin
      chk("mid_req_first_cyc", 64'(cap_q[0].cyc), 64'(frame_start_cyc + 2));
      chk("mid_req_first_addr", {61'd0, cap_q[0].addr}, 64'd0);
    end

    // Gappy random traffic with repeated and boundary-coincident requests.
    cap_q.delete();
    m_emits = 0;
    frame_rand(50, 8'h00);
    frame_rand(50, 8'b0100_0100);
    frame_rand(50, 8'h00);
    frame_rand(50, 8'b0000_1000);
    frame_rand(50, 8'h00);
    frame_rand(50, 8'b0000_0001);
    frame_rand(50, 8'h00);
    idle(4);
    chk("gap_count", 64'(cap_q.size()), 64'(m_emits));
    chk("gap_emits", 64'(m_emits), 64'd24);
    for (int i = 0; i < cap_q.size(); i++)
      chk("gap_addr_order", {61'd0, cap_q[i].addr}, 64'(i % 8));

    // 64 frames of a large positive correlation wrap the 40-bit accumulator.
    do_reset(2);
    idle(1, 1);
    repeat (64) frame_const(37'd1, 37'd2, 37'h7_FFFF_FFFF, 37'h1F_FFFF_FFFF);
    idle(1, 1);
    cap_q.delete();
    frame_const(37'd0, 37'd0, 37'd0, 37'd0);
    idle(4);
    chk("wrap_count", 64'(cap_q.size()), 64'd8);
    if (cap_q.size() > 0) begin
      chk("wrap_re40", {24'd0, cap_q[0].re40}, 64'h00_FFFF_FFFF_C0);
      chk("wrap_re64", cap_q[0].re, 64'h1FF_FFFF_FFC0);
      chk("wrap_r11", cap_q[0].r11, 64'd64);
    end

    // Reset in the middle of a dump discards the integration.
    do_reset(2);
    idle(1, 1);
    frame_rand(0, 8'h00);
    frame_rand(0, 8'h00);
    idle(1, 1);
    for (int ch = 0; ch < 4; ch++) step(1, 0, rnd37(), rnd37(), rnd37(), rnd37());
    do_reset(1);
    cap_q.delete();
    frame_rand(0, 8'h00);
    idle(3);
    chk("post_rst_idle", 64'(cap_q.size()), 64'd0);
    idle(1, 1);
    repeat (2) frame_const(37'd9, 37'd4, 37'h1F_FFFF_FFFD, 37'd11);
    idle(1, 1);
    cap_q.delete();
    frame_rand(30, 8'h00);
    idle(4);
    chk("post_rst_count", 64'(cap_q.size()), 64'd8);
    for (int i = 0; i < cap_q.size(); i++) begin
      chk("post_rst_r11", cap_q[i].r11, 64'd18);
      chk("post_rst_r22", cap_q[i].r22, 64'd8);
      chk("post_rst_re", cap_q[i].re, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("post_rst_im", cap_q[i].im, 64'd22);
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
